// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU with 13 ops, registered result and zero/overflow/carry flags.
// Latency: single-cycle ops are visible the cycle after accept; MUL iterates WIDTH shift-add steps
//   plus one result-load cycle (out_valid rises WIDTH+1 edges after the accept edge).
// Backpressure: holds y/flags and out_valid until out_ready; in_ready follows out_ready while DONE.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake; a, b, f captured on accept
//   out_valid/out_ready  result handshake; y, zf, of, cf held until taken
//   busy                 high while the multiplier is iterating
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             of,
  output logic             cf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can reach WIDTH, which marks the result-load cycle.
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [WIDTH-1:0] a_q;      // multiplicand
  logic [WIDTH-1:0] hi_q;     // upper half of the running product
  logic [WIDTH-1:0] lo_q;     // multiplier bits shifting out / lower product bits shifting in
  logic [CW-1:0]    cnt;
  logic             mul_last;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] res_y;
  logic             res_of;
  logic             res_cf;

  assign mul_last  = (cnt == CW'(WIDTH));
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: if (mul_last) state_nx = DONE;
      DONE: begin
        // Result leaves and a new op may enter on the same edge.
        in_ready = out_ready;
        if (out_ready && !in_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_nx = (f == OP_MUL) ? BUSY : DONE;
  end

  // ---------------- single-cycle datapath ----------------
  assign sh      = b[SHW-1:0];
  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_y  = '0;
    res_of = 1'b0;
    res_cf = 1'b0;
    case (f)
      OP_ADD: begin
        res_y  = sum_ext[WIDTH-1:0];
        res_cf = sum_ext[WIDTH];
        res_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_y  = dif_ext[WIDTH-1:0];
        res_cf = dif_ext[WIDTH];   // borrow out of the zero-extended subtraction
        res_of = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  res_y = ~a;
      OP_AND:  res_y = a & b;
      OP_OR:   res_y = a | b;
      OP_XOR:  res_y = a ^ b;
      OP_SLT:  res_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   res_y = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: res_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res_y = a << sh;
      OP_SRL:  res_y = a >> sh;
      OP_SRA:  res_y = $signed(a) >>> sh;
      default: res_y = '0;   // MUL is produced by the sequencer; 13-15 reserved
    endcase
  end

  // ---------------- shift-add multiplier step ----------------
  // Add the multiplicand into the top half when the current multiplier bit is set, then shift
  // the whole {carry, hi, lo} right by one. After WIDTH steps {hi, lo} is the full product.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      zf   <= 1'b0;
      of   <= 1'b0;
      cf   <= 1'b0;
      a_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt  <= '0;
    end else if (accept) begin
      if (f == OP_MUL) begin
        a_q  <= a;
        hi_q <= '0;
        lo_q <= b;
        cnt  <= '0;
      end else begin
        y  <= res_y;
        zf <= (res_y == '0);
        of <= res_of;
        cf <= res_cf;
      end
    end else if (state == BUSY) begin
      if (mul_last) begin
        y  <= lo_q;
        zf <= (lo_q == '0);
        of <= |hi_q;
        cf <= 1'b0;
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: three instances (WIDTH 4, 8, 32) share stimulus; one is selected at a time.
// Expected results are queued on issue and checked by an independent output monitor.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic [3:0]  f;
  int          sel;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v4, v8, v32;
  logic       ir4, ov4, zf4, of4, cf4, bz4;
  logic       ir8, ov8, zf8, of8, cf8, bz8;
  logic       ir32, ov32, zf32, of32, cf32, bz32;
  logic [3:0]  y4;
  logic [7:0]  y8;
  logic [31:0] y32;

  assign v4  = in_valid && (sel == 0);
  assign v8  = in_valid && (sel == 1);
  assign v32 = in_valid && (sel == 2);

  seq_alu #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .a(a[3:0]), .b(b[3:0]), .f(f),
    .out_valid(ov4), .out_ready(out_ready), .y(y4), .zf(zf4), .of(of4), .cf(cf4), .busy(bz4));
  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]), .f(f),
    .out_valid(ov8), .out_ready(out_ready), .y(y8), .zf(zf8), .of(of8), .cf(cf8), .busy(bz8));
  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .a(a), .b(b), .f(f),
    .out_valid(ov32), .out_ready(out_ready), .y(y32), .zf(zf32), .of(of32), .cf(cf32), .busy(bz32));

  // Selected instance's outputs, y zero-extended to 32 bits.
  logic        s_ir, s_ov, s_zf, s_of, s_cf, s_bz;
  logic [31:0] s_y;
  always_comb begin
    s_ir = ir32; s_ov = ov32; s_y = y32; s_zf = zf32; s_of = of32; s_cf = cf32; s_bz = bz32;
    case (sel)
      0: begin s_ir = ir4; s_ov = ov4; s_y = {28'd0, y4}; s_zf = zf4; s_of = of4; s_cf = cf4; s_bz = bz4; end
      1: begin s_ir = ir8; s_ov = ov8; s_y = {24'd0, y8}; s_zf = zf8; s_of = of8; s_cf = cf8; s_bz = bz8; end
      default: ;
    endcase
  end

  typedef struct {
    logic [34:0] exp;   // {y, zf, of, cf}
    int          acc;   // index of the accept edge
    int          lat;   // edges from accept edge to out_valid
    string       nm;
  } ent_t;
  ent_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] pk(input logic [31:0] yv, input logic z, input logic o, input logic c);
    return {yv, z, o, c};
  endfunction

  // Reference model using wide integer arithmetic; overflow is a range check on signed values.
  function automatic logic [34:0] model(input int w, input logic [3:0] op,
                                        input logic [31:0] av, input logic [31:0] bv);
    longint unsigned m, ua, ub, r, p;
    longint sa, sb, s, smax, smin;
    int sh;
    logic z, o, c;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, av} & m;
    ub = {32'd0, bv} & m;
    sa = ((ua >> (w-1)) & 64'd1) != 0 ? longint'(ua) - longint'(m) - 1 : longint'(ua);
    sb = ((ub >> (w-1)) & 64'd1) != 0 ? longint'(ub) - longint'(m) - 1 : longint'(ub);
    smax = longint'(m >> 1);
    smin = -smax - 1;
    sh = int'(ub & longint'(w - 1));
    r = 0; o = 1'b0; c = 1'b0;
    case (op)
      4'd0: begin r = (ua + ub) & m; c = (ua + ub) > m; s = sa + sb; o = (s > smax) || (s < smin); end
      4'd1: begin r = (ua - ub) & m; c = ua < ub;       s = sa - sb; o = (s > smax) || (s < smin); end
      4'd2: r = ~ua & m;
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: r = (sa < sb) ? 1 : 0;
      4'd7: r = (ua == ub) ? 1 : 0;
      4'd8: r = (ua < ub) ? 1 : 0;
      4'd9: r = (ua << sh) & m;
      4'd10: r = ua >> sh;
      4'd11: begin s = sa >>> sh; r = longint'(s) & m; end
      4'd12: begin p = ua * ub; r = p & m; o = (p >> w) != 0; end
      default: r = 0;
    endcase
    z = (r == 0);
    return {r[31:0], z, o, c};
  endfunction

  // Monitor: samples 1 time unit after the falling edge; a handshake happens at the next rising edge.
  logic seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 1'b0;
      end else if (s_ov) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got out_valid=1 y=%0h expected no output (t=%0t)", s_y, $time);
        end else begin
          if (!seen) begin
            chk({q[0].nm, "_lat"}, longint'(cyc - q[0].acc), longint'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            chk(q[0].nm, longint'({s_y, s_zf, s_of, s_cf}), longint'(q[0].exp));
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present an op at a falling edge and hold it until accepted; returns at the next falling edge.
  task automatic issue(input string nm, input logic [3:0] ff, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [34:0] exp, input int lat, output int waits);
    ent_t e;
    in_valid = 1'b1; f = ff; a = aa; b = bb; waits = 0;
    #1;
    while (!s_ir) begin
      waits++;
      if (waits > 100) begin
        chk({nm, "_accept_timeout"}, 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.exp = exp; e.acc = cyc + 1; e.lat = lat; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", longint'(q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int nov;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; f = '0; sel = 0;

    // Reset state of every instance.
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_out_valid", longint'(s_ov), 0);
      chk("rst_busy", longint'(s_bz), 0);
      chk("rst_y_flags", longint'({s_y, s_zf, s_of, s_cf}), 0);
      chk("rst_in_ready", longint'(s_ir), 1);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=4: all operand pairs for ops 0-11, back to back.
    for (int op = 0; op < 12; op++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          issue("w4_exh", 4'(op), 32'(ai), 32'(bi), model(4, 4'(op), 32'(ai), 32'(bi)), 0, w);
    // WIDTH=4 directed flag corners.
    issue("w4_add_7p1",  4'd0, 32'd7,  32'd1, pk(32'd8,  1'b0, 1'b1, 1'b0), 0, w);
    issue("w4_add_15p1", 4'd0, 32'd15, 32'd1, pk(32'd0,  1'b1, 1'b0, 1'b1), 0, w);
    issue("w4_sub_0m1",  4'd1, 32'd0,  32'd1, pk(32'd15, 1'b0, 1'b0, 1'b1), 0, w);
    // WIDTH=4 multiply: product overflow and plain cases, WIDTH+1 edges to result.
    issue("w4_mul_15x15", 4'd12, 32'd15, 32'd15, pk(32'd1,  1'b0, 1'b1, 1'b0), 5, w);
    issue("w4_mul_3x5",   4'd12, 32'd3,  32'd5,  pk(32'd15, 1'b0, 1'b0, 1'b0), 5, w);
    issue("w4_mul_0x9",   4'd12, 32'd0,  32'd9,  pk(32'd0,  1'b1, 1'b0, 1'b0), 5, w);
    drain();

    // WIDTH=8: shifts with upper amount bits ignored, signed/unsigned compare, reserved op.
    sel = 1;
    issue("w8_sra",    4'd11, 32'h80, 32'hF3, pk(32'hF0, 1'b0, 1'b0, 1'b0), 0, w);
    issue("w8_slt",    4'd6,  32'hFF, 32'h01, pk(32'h01, 1'b0, 1'b0, 1'b0), 0, w);
    issue("w8_sltu",   4'd8,  32'hFF, 32'h01, pk(32'h00, 1'b1, 1'b0, 1'b0), 0, w);
    issue("w8_rsvd14", 4'd14, 32'h55, 32'h33, pk(32'h00, 1'b1, 1'b0, 1'b0), 0, w);
    issue("w8_sll_0",  4'd9,  32'h81, 32'h08, pk(32'h81, 1'b0, 1'b0, 1'b0), 0, w);
    issue("w8_srl_7",  4'd10, 32'h80, 32'h07, pk(32'h01, 1'b0, 1'b0, 1'b0), 0, w);
    issue("w8_mul",    4'd12, 32'h10, 32'h11, pk(32'h10, 1'b0, 1'b1, 1'b0), 9, w);
    drain();

    // WIDTH=32 multiply whose low half is zero.
    sel = 2;
    issue("w32_mul_2p16sq", 4'd12, 32'h0001_0000, 32'h0001_0000, pk(32'd0, 1'b1, 1'b1, 1'b0), 33, w);
    issue("w32_mul_small",  4'd12, 32'd1234,      32'd5678,      pk(32'd7006652, 1'b0, 1'b0, 1'b0), 33, w);
    drain();

    // Backpressure: result held while out_ready=0, inputs ignored, then back-to-back handoff.
    out_ready = 1'b0;
    issue("w32_add_hold", 4'd0, 32'd5, 32'd6, pk(32'd11, 1'b0, 1'b0, 1'b0), 0, w);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; f = 4'($urandom_range(0, 15));
      #1;
      chk("hold_in_ready", longint'(s_ir), 0);
      chk("hold_out_valid", longint'(s_ov), 1);
      chk("hold_y_flags", longint'({s_y, s_zf, s_of, s_cf}), longint'(pk(32'd11, 1'b0, 1'b0, 1'b0)));
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue("w32_sub_b2b", 4'd1, 32'd20, 32'd7, pk(32'd13, 1'b0, 1'b0, 1'b0), 0, w);
    chk("b2b_no_wait", longint'(w), 0);
    drain();

    // Reset in the middle of a multiply.
    issue("w32_mul_killed", 4'd12, 32'd7, 32'd9, pk(32'd63, 1'b0, 1'b0, 1'b0), 33, w);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_mul_busy", longint'(s_bz), 1);
    chk("mid_mul_in_ready", longint'(s_ir), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", longint'(s_ov), 0);
    chk("arst_busy", longint'(s_bz), 0);
    chk("arst_y_flags", longint'({s_y, s_zf, s_of, s_cf}), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nov = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (s_ov) nov++;
    end
    chk("no_result_after_reset", longint'(nov), 0);
    chk("idle_after_reset", longint'(s_ir), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
